// File: rtl/postmortem_reader.sv
`default_nettype none
// ============================================================================
// Module   : postmortem_reader
// Purpose  : Read-back engine for the frozen postmortem capture ring in DDR.
//            Reads DEPTH samples oldest-first across five 64-bit regions and
//            presents each record on a valid/ready stream.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_req                 one-cycle dump request (IDLE only)
//   i_frozen              capture buffer is halted and stable
//   i_wr_ptr[15:0]        writer's next slot (= oldest sample)
//   o_rd_start, o_rd_addr DDR read request (level) and byte address
//   i_rd_done, i_rd_data  DDR read completion and data
//   o_data, o_valid       stream data / valid
//   i_ready               stream ready
//   o_last                final beat of the dump
//   o_region, o_index     region (0..4) and chronological index of the beat
//   o_busy, o_done, o_err status; done/err are one-cycle pulses
//   o_state               state encoding for debug
// ============================================================================
module postmortem_reader #(
  parameter int          DEPTH = 50000,
  parameter logic [39:0] BASE0 = 40'h40_0000,
  parameter logic [39:0] BASE1 = 40'h50_0000,
  parameter logic [39:0] BASE2 = 40'h60_0000,
  parameter logic [39:0] BASE3 = 40'h70_0000,
  parameter logic [39:0] BASE4 = 40'h80_0000,
  parameter int          STEP  = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_frozen,
  input  logic [15:0] i_wr_ptr,
  output logic        o_rd_start,
  output logic [39:0] o_rd_addr,
  input  logic        i_rd_done,
  input  logic [63:0] i_rd_data,
  output logic [63:0] o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_last,
  output logic [2:0]  o_region,
  output logic [15:0] o_index,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_OUT  = 3'd2,
    ST_NEXT = 3'd3,
    ST_FIN  = 3'd4,
    ST_ABRT = 3'd5
  } state_t;

  localparam logic [16:0] c_depth    = 17'(DEPTH);
  localparam logic [15:0] c_last_idx = 16'(DEPTH - 1);
  localparam logic [39:0] c_step     = 40'(STEP);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_start;
  logic [15:0] r_idx;
  logic [2:0]  r_region;
  logic        r_abort;
  logic        r_rej;
  logic [63:0] r_data;

  logic        w_accept;
  logic        w_reject;
  logic        w_abort_now;
  logic        w_last;
  logic [16:0] w_sum;
  logic [16:0] w_slot;
  logic [39:0] w_base;
  logic [39:0] w_addr;

  assign w_accept    = (r_state == ST_IDLE) & i_req & i_frozen;
  assign w_reject    = (r_state == ST_IDLE) & i_req & ~i_frozen;
  // A freeze loss seen in the same cycle as a completion must still abort.
  assign w_abort_now = r_abort | ~i_frozen;
  assign w_last      = (r_idx == c_last_idx) & (r_region == 3'd4);

  // Ring position: start + idx folded back once; both operands are < DEPTH.
  assign w_sum  = {1'b0, r_start} + {1'b0, r_idx};
  assign w_slot = (w_sum >= c_depth) ? (w_sum - c_depth) : w_sum;

  always_comb begin
    w_base = BASE0;
    case (r_region)
      3'd1:    w_base = BASE1;
      3'd2:    w_base = BASE2;
      3'd3:    w_base = BASE3;
      3'd4:    w_base = BASE4;
      default: w_base = BASE0;
    endcase
  end

  assign w_addr = w_base + (40'(w_slot) * c_step);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    o_rd_start  = 1'b0;
    o_rd_addr   = '0;
    o_valid     = 1'b0;
    o_last      = 1'b0;
    o_done      = 1'b0;
    o_err       = r_rej;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_RD;
      end
      ST_RD: begin
        o_rd_start = 1'b1;
        o_rd_addr  = w_addr;
        if (i_rd_done) w_state_nxt = w_abort_now ? ST_ABRT : ST_OUT;
      end
      ST_OUT: begin
        o_valid = 1'b1;
        o_last  = w_last;
        if (i_ready) begin
          if (w_last)           w_state_nxt = ST_FIN;
          else if (w_abort_now) w_state_nxt = ST_ABRT;
          else                  w_state_nxt = ST_NEXT;
        end
      end
      ST_NEXT: w_state_nxt = ST_RD;
      ST_FIN: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_ABRT: begin
        o_err       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: start slot, counters, abort flag, captured data
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_start  <= '0;
      r_idx    <= '0;
      r_region <= '0;
      r_abort  <= 1'b0;
      r_rej    <= 1'b0;
      r_data   <= '0;
    end else begin
      r_rej   <= w_reject;
      r_abort <= (r_state == ST_IDLE) ? 1'b0 : (r_abort | ~i_frozen);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            // An out-of-range pointer cannot name a valid slot; start at 0.
            r_start  <= ({1'b0, i_wr_ptr} >= c_depth) ? 16'd0 : i_wr_ptr;
            r_idx    <= '0;
            r_region <= '0;
          end
        end
        ST_RD: begin
          if (i_rd_done && !w_abort_now) r_data <= i_rd_data;
        end
        ST_NEXT: begin
          if (r_region == 3'd4) begin
            r_region <= '0;
            r_idx    <= r_idx + 16'd1;
          end else begin
            r_region <= r_region + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_data   = r_data;
  assign o_region = r_region;
  assign o_index  = r_idx;
  assign o_busy   = (r_state != ST_IDLE);
  assign o_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_postmortem_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_postmortem_reader
// Purpose  : Self-checking bench for postmortem_reader (DEPTH = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_postmortem_reader;

  localparam int DEPTH = 4;
  localparam int NB    = DEPTH * 5;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req = 1'b0;
  logic        i_frozen = 1'b1;
  logic [15:0] i_wr_ptr = '0;
  logic        o_rd_start;
  logic [39:0] o_rd_addr;
  logic        i_rd_done;
  logic [63:0] i_rd_data;
  logic [63:0] o_data;
  logic        o_valid;
  logic        i_ready;
  logic        o_last;
  logic [2:0]  o_region;
  logic [15:0] o_index;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [2:0]  o_state;

  postmortem_reader #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_frozen(i_frozen),
    .i_wr_ptr(i_wr_ptr), .o_rd_start(o_rd_start), .o_rd_addr(o_rd_addr),
    .i_rd_done(i_rd_done), .i_rd_data(i_rd_data), .o_data(o_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
    .o_region(o_region), .o_index(o_index), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Chronological read address of beat b for a dump starting at slot start.
  function automatic logic [39:0] model_addr(input int start, input int b);
    int          slot;
    logic [39:0] base;
    slot = (start + b / 5) % DEPTH;
    case (b % 5)
      0:       base = 40'h40_0000;
      1:       base = 40'h50_0000;
      2:       base = 40'h60_0000;
      3:       base = 40'h70_0000;
      default: base = 40'h80_0000;
    endcase
    return base + 40'(slot * 8);
  endfunction

  // Responder controls written by the main process only.
  int lat_fixed = 2;
  bit rand_ready = 1'b0;
  int bp_token = 0;

  // Model state written by the compare process only.
  int          cyc = 0;
  bit          m_active = 0, m_read = 0, m_beat_on = 0, m_abort = 0;
  int          m_beat = 0, m_start = 0;
  logic [63:0] m_data = '0;
  int          t_read = -1, t_valid = -1, t_done = -1, t_err = -1, t_idle = -1;
  logic [39:0] rd_log[$];
  int          last_log = -1;
  int          n_errp = 0, n_donep = 0;

  // --------------------------------------------------------------------------
  // DDR responder and stream sink
  // --------------------------------------------------------------------------
  initial begin : p_resp
    int cnt;
    bit pend;
    int seen;
    int ready_low;
    cnt = 0; pend = 0; seen = 0; ready_low = 0;
    i_rd_done = 1'b0;
    i_rd_data = '0;
    i_ready   = 1'b1;
    forever begin
      @(posedge i_clk);
      #2;
      i_rd_done = 1'b0;
      if (i_rst) begin
        pend = 0;
      end else if (pend) begin
        if (cnt == 0) begin
          i_rd_done = 1'b1;
          i_rd_data = {24'($urandom()), o_rd_addr};
          pend = 0;
        end else begin
          cnt--;
        end
      end else if (o_rd_start) begin
        pend = 1;
        cnt  = ((lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3))) - 1;
      end
      if (bp_token != seen) begin
        seen = bp_token;
        ready_low = 5;
      end
      if (ready_low > 0) begin
        i_ready = 1'b0;
        ready_low--;
      end else begin
        i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Compare process: event-scheduled model of the dump, checked every cycle
  // --------------------------------------------------------------------------
  initial begin : p_compare
    forever begin
      @(negedge i_clk);
      cyc++;
      if (i_rst) begin
        chk("rst_ctrl", {58'd0, o_rd_start, o_valid, o_last, o_busy, o_done, o_err}, 64'd0);
        chk("rst_addr", {24'd0, o_rd_addr}, 64'd0);
        chk("rst_data", o_data, 64'd0);
        chk("rst_pos", {42'd0, o_state, o_region, o_index}, 64'd0);
        m_active = 0; m_read = 0; m_beat_on = 0; m_abort = 0;
        t_read = -1; t_valid = -1; t_done = -1; t_err = -1; t_idle = -1;
        continue;
      end
      if (cyc == t_read)  m_read = 1;
      if (cyc == t_valid) m_beat_on = 1;
      if (cyc == t_idle)  m_active = 0;

      chk("rd_start", {63'd0, o_rd_start}, {63'd0, m_read});
      chk("valid", {63'd0, o_valid}, {63'd0, m_beat_on});
      chk("done", {63'd0, o_done}, {63'd0, (cyc == t_done)});
      chk("err", {63'd0, o_err}, {63'd0, (cyc == t_err)});
      chk("busy", {63'd0, o_busy}, {63'd0, m_active});
      if (!m_active) chk("state_idle", {61'd0, o_state}, 64'd0);
      if (m_read) begin
        chk("rd_addr", {24'd0, o_rd_addr}, {24'd0, model_addr(m_start, m_beat)});
        chk("state_rd", {61'd0, o_state}, 64'd1);
      end
      if (cyc == t_read) rd_log.push_back(o_rd_addr);
      if (m_beat_on) begin
        chk("data", o_data, m_data);
        chk("region", {61'd0, o_region}, 64'(m_beat % 5));
        chk("index", {48'd0, o_index}, 64'(m_beat / 5));
        chk("last", {63'd0, o_last}, {63'd0, (m_beat == NB - 1)});
      end
      if (o_err)  n_errp++;
      if (o_done) n_donep++;

      // Events of this cycle
      if (m_active && !i_frozen) m_abort = 1;
      if (m_read && i_rd_done) begin
        m_read = 0;
        if (m_abort) begin
          t_err = cyc + 1; t_idle = cyc + 2;
        end else begin
          m_data = i_rd_data; t_valid = cyc + 1;
        end
      end
      if (m_beat_on && i_ready) begin
        m_beat_on = 0;
        if (o_last) last_log = m_beat;
        if (m_beat == NB - 1) begin
          t_done = cyc + 1; t_idle = cyc + 2;
        end else if (m_abort) begin
          t_err = cyc + 1; t_idle = cyc + 2;
        end else begin
          m_beat++; t_read = cyc + 2;
        end
      end
      if (!m_active && i_req) begin
        if (i_frozen) begin
          m_active = 1; m_abort = 0; m_beat = 0;
          m_start  = (int'(i_wr_ptr) >= DEPTH) ? 0 : int'(i_wr_ptr);
          t_read   = cyc + 1;
          rd_log.delete();
          last_log = -1;
        end else begin
          t_err = cyc + 1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Main stimulus
  // --------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic pulse_req(input logic [15:0] wp);
    i_req = 1'b1;
    i_wr_ptr = wp;
    step(1);
    i_req = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int k;
    k = 0;
    while (o_busy && k < maxc) begin
      step(1);
      k++;
    end
    chk("idle_reached", {63'd0, o_busy}, 64'd0);
    step(2);
  endtask

  task automatic wait_valid(input int maxc);
    int k;
    k = 0;
    while (!o_valid && k < maxc) begin
      step(1);
      k++;
    end
    chk("valid_seen", {63'd0, o_valid}, 64'd1);
  endtask

  initial begin : p_main
    int e0, d0, k;
    step(3);
    i_rst = 1'b0;
    step(2);

    // Basic dump, fixed latency 2, always ready
    lat_fixed = 2; rand_ready = 1'b0;
    pulse_req(16'd0);
    wait_idle(400);
    chk("basic_nreads", 64'(rd_log.size()), 64'd20);
    chk("basic_beat1", {24'd0, rd_log[0]}, 64'h40_0000);
    chk("basic_beat2", {24'd0, rd_log[1]}, 64'h50_0000);
    chk("basic_beat20", {24'd0, rd_log[19]}, 64'h80_0018);
    chk("basic_last_at", 64'(last_log), 64'd19);

    // Wrap from slot 3
    pulse_req(16'd3);
    wait_idle(400);
    chk("wrap_beat1", {24'd0, rd_log[0]}, 64'h40_0018);
    chk("wrap_beat6", {24'd0, rd_log[5]}, 64'h40_0000);
    chk("wrap_beat20", {24'd0, rd_log[19]}, 64'h80_0010);
    chk("wrap_last_at", 64'(last_log), 64'd19);

    // Backpressure on beat 3
    pulse_req(16'd1);
    k = 0;
    while (!(o_valid && m_beat == 2) && k < 100) begin
      step(1);
      k++;
    end
    chk("bp_beat3_seen", {63'd0, o_valid}, 64'd1);
    bp_token++;
    wait_idle(400);

    // Rejected request, then a request while busy is ignored
    i_frozen = 1'b0;
    e0 = n_errp;
    pulse_req(16'd2);
    step(3);
    chk("rej_err_pulses", 64'(n_errp - e0), 64'd1);
    chk("rej_busy", {63'd0, o_busy}, 64'd0);
    i_frozen = 1'b1;
    pulse_req(16'd0);
    step(3);
    pulse_req(16'd1);
    wait_idle(400);
    chk("busy_req_ignored", {24'd0, rd_log[0]}, 64'h40_0000);

    // Out-of-range write pointer starts at slot 0
    pulse_req(16'd7);
    wait_idle(400);
    chk("oor_beat1", {24'd0, rd_log[0]}, 64'h40_0000);

    // Abort during a slow read
    lat_fixed = 3;
    e0 = n_errp; d0 = n_donep;
    pulse_req(16'd0);
    i_frozen = 1'b0;
    wait_idle(100);
    i_frozen = 1'b1;
    chk("abort_err_pulses", 64'(n_errp - e0), 64'd1);
    chk("abort_done_pulses", 64'(n_donep - d0), 64'd0);

    // Reset while a beat is offered
    lat_fixed = 1;
    pulse_req(16'd2);
    wait_valid(50);
    i_rst = 1'b1;
    #1;
    chk("async_rst", {61'd0, o_rd_start, o_valid, o_busy}, 64'd0);
    step(2);
    i_rst = 1'b0;
    step(1);
    pulse_req(16'd2);
    wait_idle(400);
    chk("post_rst_beat1", {24'd0, rd_log[0]}, 64'h40_0010);

    // Randomized dumps with random latency, ready and freeze loss
    lat_fixed = 0; rand_ready = 1'b1;
    for (int r = 0; r < 16; r++) begin
      pulse_req(16'($urandom_range(0, 5)));
      if ($urandom_range(0, 2) == 0) begin
        step(int'($urandom_range(0, 60)));
        i_frozen = 1'b0;
      end
      wait_idle(600);
      i_frozen = 1'b1;
      step(int'($urandom_range(0, 3)));
    end

    step(5);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin : p_watchdog
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
